cmul_seq_ctrl: RTL and testbench



---
 rtl/cmul_pkg.sv | 34 +++
 rtl/vedic8.sv | 20 ++
 rtl/cmul_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cmul_seq_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmul_pkg.sv
// Shared constants, FSM/index encodings and operand bundle for the sequential complex multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmul_pkg;

  localparam int DATA_W = 8;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 17;

  // FSM state encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUL   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Partial-product order through the shared multiplier
  localparam logic [1:0] IDX_AC = 2'd0;  // a_re*b_re -> +re
  localparam logic [1:0] IDX_BD = 2'd1;  // a_im*b_im -> -re
  localparam logic [1:0] IDX_AD = 2'd2;  // a_re*b_im -> +im
  localparam logic [1:0] IDX_BC = 2'd3;  // a_im*b_re -> +im

  typedef struct packed {
    logic [DATA_W-1:0] a_re;
    logic [DATA_W-1:0] a_im;
    logic [DATA_W-1:0] b_re;
    logic [DATA_W-1:0] b_im;
  } operands_t;

  // Absolute value as unsigned; -128 maps to 8'h80 (=128), which is exactly what the multiplier needs.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? ((~x) + {{(DATA_W-1){1'b0}}, 1'b1}) : x;
  endfunction

endpackage

// File: rtl/vedic8.sv
// 8x8 unsigned multiplier, Urdhva-style split into four 4x4 nibble products.
// Latency: combinational. Backpressure: none.
// Ports: a_i, b_i 8-bit unsigned operands; p_o 16-bit unsigned product.
module vedic8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  logic [7:0] pp_ll, pp_lh, pp_hl, pp_hh;

  assign pp_ll = {4'd0, a_i[3:0]} * {4'd0, b_i[3:0]};
  assign pp_lh = {4'd0, a_i[3:0]} * {4'd0, b_i[7:4]};
  assign pp_hl = {4'd0, a_i[7:4]} * {4'd0, b_i[3:0]};
  assign pp_hh = {4'd0, a_i[7:4]} * {4'd0, b_i[7:4]};

  // Cross terms sit at nibble weight 4; outer terms concatenate directly.
  assign p_o = {pp_hh, pp_ll} + ({8'd0, pp_lh} << 4) + ({8'd0, pp_hl} << 4);

endmodule

// File: rtl/cmul_seq_ctrl.sv
// Sequential signed complex multiply over one shared vedic8; ac, bd, ad, bc partial products in turn.
// Latency: out_valid 4 cycles after acceptance (5 with CMUL_MULREG_EN, which registers the product and adds DRAIN).
// Backpressure: result and out_valid held in DONE until out_ready; in_ready only in IDLE, one cycle after handoff.
// Ports: clk, rst_n (async low); in_valid/in_ready + a_re,a_im,b_re,b_im (signed 8b);
//        out_valid/out_ready + p_re,p_im (signed 17b); busy = not IDLE.
module cmul_seq_ctrl
  import cmul_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        a_re,
  input  logic [DATA_W-1:0]        a_im,
  input  logic [DATA_W-1:0]        b_re,
  input  logic [DATA_W-1:0]        b_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  p_re,
  output logic signed [ACC_W-1:0]  p_im,
  output logic                     busy
);

  logic [1:0]              state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  operands_t               ops_q, ops_d;
  logic signed [ACC_W-1:0] p_re_q, p_re_d;
  logic signed [ACC_W-1:0] p_im_q, p_im_d;

  logic [DATA_W-1:0]       op_x, op_y;
  logic [PROD_W-1:0]       prod;
  logic                    prod_neg;

  logic [PROD_W-1:0]       acc_prod;
  logic                    acc_neg;
  logic [1:0]              acc_sel;
  logic                    acc_en;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] corr;

  // Operand pair for the current partial product
  always_comb begin
    case (idx_q)
      IDX_AC:  begin op_x = ops_q.a_re; op_y = ops_q.b_re; end
      IDX_BD:  begin op_x = ops_q.a_im; op_y = ops_q.b_im; end
      IDX_AD:  begin op_x = ops_q.a_re; op_y = ops_q.b_im; end
      default: begin op_x = ops_q.a_im; op_y = ops_q.b_re; end
    endcase
  end

  assign prod_neg = op_x[DATA_W-1] ^ op_y[DATA_W-1];

  vedic8 u_mul (
    .a_i (magnitude(op_x)),
    .b_i (magnitude(op_y)),
    .p_o (prod)
  );

`ifdef CMUL_MULREG_EN
  // Product stage: the accumulator sees each product one cycle after it is formed,
  // tagged with the index it was formed under.
  logic [PROD_W-1:0] prod_q;
  logic              neg_q;
  logic [1:0]        sel_q;
  logic              pvld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      neg_q  <= 1'b0;
      sel_q  <= IDX_AC;
      pvld_q <= 1'b0;
    end else begin
      prod_q <= prod;
      neg_q  <= prod_neg;
      sel_q  <= idx_q;
      pvld_q <= (state_q == S_MUL);
    end
  end

  assign acc_prod = prod_q;
  assign acc_neg  = neg_q;
  assign acc_sel  = sel_q;
  assign acc_en   = pvld_q;
`else
  assign acc_prod = prod;
  assign acc_neg  = prod_neg;
  assign acc_sel  = idx_q;
  assign acc_en   = (state_q == S_MUL);
`endif

  assign prod_ext = {1'b0, acc_prod};
  assign corr     = acc_neg ? -prod_ext : prod_ext;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ops_d   = ops_q;
    p_re_d  = p_re_q;
    p_im_d  = p_im_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ops_d   = {a_re, a_im, b_re, b_im};
          p_re_d  = '0;
          p_im_d  = '0;
          idx_d   = IDX_AC;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == IDX_BC) begin
`ifdef CMUL_MULREG_EN
          state_d = S_DRAIN;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef CMUL_MULREG_EN
      S_DRAIN: state_d = S_DONE;
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Never active in IDLE, so it cannot collide with the accumulator clear above.
    if (acc_en) begin
      case (acc_sel)
        IDX_AC:  p_re_d = p_re_q + corr;
        IDX_BD:  p_re_d = p_re_q - corr;
        default: p_im_d = p_im_q + corr;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_AC;
      ops_q   <= '0;
      p_re_q  <= '0;
      p_im_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ops_q   <= ops_d;
      p_re_q  <= p_re_d;
      p_im_q  <= p_im_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign p_re      = p_re_q;
  assign p_im      = p_im_q;

endmodule

// File: tb/tb_cmul_seq_ctrl.sv
module tb_cmul_seq_ctrl;

`ifdef CMUL_MULREG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  localparam int II = LAT + 2;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        a_re, a_im, b_re, b_im;
  logic              out_valid;
  logic              out_ready;
  logic signed [16:0] p_re, p_im;
  logic              busy;

  int checks = 0;
  int errors = 0;

  cmul_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_re      (p_re),
    .p_im      (p_im),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic scramble();
    a_re = 8'($urandom);
    a_im = 8'($urandom);
    b_re = 8'($urandom);
    b_im = 8'($urandom);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "/in_ready"},  32'(in_ready),  1);
    check({tag, "/out_valid"}, 32'(out_valid), 0);
    check({tag, "/busy"},      32'(busy),      0);
    check({tag, "/p_re"},      p_re,           0);
    check({tag, "/p_im"},      p_im,           0);
  endtask

  // One full transaction: accept, measure latency, hold the result for 'hold' cycles, then hand off.
  task automatic do_op(input string tag, input int ar, input int ai, input int br, input int bi, input int hold);
    int lat;
    int er, ei;
    er = ar * br - ai * bi;
    ei = ar * bi + ai * br;

    @(negedge clk);
    check({tag, "/in_ready_idle"}, 32'(in_ready), 1);
    in_valid  = 1'b1;
    a_re      = 8'(ar);
    a_im      = 8'(ai);
    b_re      = 8'(br);
    b_im      = 8'(bi);
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
    check({tag, "/busy"},     32'(busy),     1);
    check({tag, "/in_ready"}, 32'(in_ready), 0);

    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      scramble();
    end
    check({tag, "/latency"}, lat,  LAT);
    check({tag, "/p_re"},    p_re, er);
    check({tag, "/p_im"},    p_im, ei);

    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "/hold_valid"},    32'(out_valid), 1);
      check({tag, "/hold_re"},       p_re,           er);
      check({tag, "/hold_im"},       p_im,           ei);
      check({tag, "/hold_in_ready"}, 32'(in_ready),  0);
    end

    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "/post_valid"},    32'(out_valid), 0);
    check({tag, "/post_in_ready"}, 32'(in_ready),  1);
  endtask

  // in_valid stays high while three operand sets are offered in turn.
  task automatic back_to_back();
    int s[3][4];
    int acc_cyc[3];
    int na, nr, cyc;
    na = 0;
    nr = 0;
    cyc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++)
        s[i][j] = rnd8();
    out_ready = 1'b1;
    while (cyc < 80 && (na < 3 || nr < 3)) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (nr < 3) begin
          check("b2b/p_re", p_re, s[nr][0] * s[nr][2] - s[nr][1] * s[nr][3]);
          check("b2b/p_im", p_im, s[nr][0] * s[nr][3] + s[nr][1] * s[nr][2]);
        end
        nr++;
      end
      if (na < 3) begin
        in_valid = 1'b1;
        a_re = 8'(s[na][0]);
        a_im = 8'(s[na][1]);
        b_re = 8'(s[na][2]);
        b_im = 8'(s[na][3]);
        if (in_ready) begin
          acc_cyc[na] = cyc;
          na++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b/accepted", na, 3);
    check("b2b/results",  nr, 3);
    if (na == 3) begin
      check("b2b/gap01", acc_cyc[1] - acc_cyc[0], II);
      check("b2b/gap12", acc_cyc[2] - acc_cyc[1], II);
    end
  endtask

  // Reset asserted in the MUL cycle that works on idx=2.
  task automatic reset_mid_op();
    int seen;
    @(negedge clk);
    in_valid  = 1'b1;
    a_re      = 8'(rnd8());
    a_im      = 8'(rnd8());
    b_re      = 8'(rnd8());
    b_im      = 8'(rnd8());
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst/no_out", seen, 0);
  endtask

  task automatic random_ops(input int n);
    int ar, ai, br, bi;
    for (int k = 0; k < n; k++) begin
      ar = rnd8();
      ai = rnd8();
      br = rnd8();
      bi = rnd8();
      do_op("rand", ar, ai, br, bi, int'($urandom_range(3)));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_re = '0;
    a_im = '0;
    b_re = '0;
    b_im = '0;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_op("c34x56",    3,    4,    5,    6,  0);
    do_op("m128sq", -128, -128, -128, -128,  0);
    do_op("m128x127", -128,  0,  127,    0,  0);
    do_op("bp_1p1",    1,    1,    1,   -1, 10);
    back_to_back();
    reset_mid_op();
    do_op("after_rst", 7, -9, -12, 5, 0);
    random_ops(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
